eth_tx_framer: RTL and testbench

- Downstream TX stage for the ICMP echo responder and other reply generators.
- Consumes the 9-bit reply stream: bit8 = body byte valid; body bytes are followed by FCS-slot bytes with bit8 low.
- Prepends preamble and SFD, streams the body, appends a freshly computed Ethernet CRC-32 FCS, and enforces the inter-frame gap.
- Output drives the GMII TX byte interface.

---
 rtl/eth_tx_framer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   GMII transmit framer placed behind the reply generators. It takes a 9-bit
//   byte stream (bit 8 = body byte valid), sends preamble + SFD, the body
//   (delayed through a short line so the preamble can go first), a freshly
//   computed CRC-32 FCS, and then an inter-frame gap.
//
//   Optional build macro: TX_MIN_PAD_EN -- when defined, bodies shorter than
//   60 bytes are padded with 0x00 up to 60 bytes, and the padding is covered
//   by the FCS. When undefined, short bodies go straight to the FCS.
//
// Ports
//   eth_rxck   in   byte clock
//   rst_rx_n   in   asynchronous active-low reset
//   tx_i[8:0]  in   [8] body byte valid, [7:0] byte
//   gmii_txd   out  GMII transmit byte (registered)
//   gmii_txen  out  GMII transmit enable (registered)
//   busy_o     out  high whenever the framer is not idle
//   drop_o     out  one-cycle pulse: a frame start arrived while busy and was dropped
//   trunc_o    out  one-cycle pulse: a frame hit MAX_FRAME and was cut short
module eth_tx_framer #(
  parameter int unsigned PREAMB_LEN = 7,
  parameter int unsigned IFG_LEN    = 12,
  parameter int unsigned MAX_FRAME  = 1514
) (
  input  logic       eth_rxck,
  input  logic       rst_rx_n,
  input  logic [8:0] tx_i,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       busy_o,
  output logic       drop_o,
  output logic       trunc_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_FCS  = 3'd5;
  localparam logic [2:0] ST_IFG  = 3'd6;

  // The line is one entry longer than the preamble so the first body byte
  // reaches the tail exactly when the SFD is on the wire.
  localparam int          DL_LEN   = int'(PREAMB_LEN) + 1;
  localparam logic [7:0]  PRE_LAST = 8'(PREAMB_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [10:0] MIN_BODY = 11'd60;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  // Reflected CRC-32 update with one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [10:0]       bcnt_q, bcnt_d;
  logic [31:0]       crc_q, crc_d;
  logic              bad_q, bad_d;
  logic              in_frame_q, in_frame_d;
  logic              vld_prev_q;
  logic [7:0]        txd_q, txd_d;
  logic              txen_q, txen_d;
  logic              busy_q;
  logic              drop_q;
  logic              trunc_q;
  logic [7:0]        dl_data_q [DL_LEN];
  logic [DL_LEN-1:0] dl_vld_q;

  logic              rise_s;
  logic              accept_s;
  logic              drop_s;
  logic              in_vld_s;
  logic              trunc_s;
  logic              short_s;
  logic              tail_vld_s;
  logic [7:0]        tail_data_s;
  logic [31:0]       fcs_s;

  assign rise_s      = tx_i[8] & ~vld_prev_q;
  assign accept_s    = rise_s & (state_q == ST_IDLE);
  assign drop_s      = rise_s & (state_q != ST_IDLE);
  assign in_vld_s    = tx_i[8] & (accept_s | in_frame_q);
  assign tail_vld_s  = dl_vld_q[DL_LEN-1];
  assign tail_data_s = dl_data_q[DL_LEN-1];
  // A truncated frame sends the raw CRC register, i.e. the inverse of the good FCS.
  assign fcs_s       = bad_q ? crc_q : ~crc_q;

`ifdef TX_MIN_PAD_EN
  assign short_s = (bcnt_q < MIN_BODY);
`else
  assign short_s = 1'b0;
`endif

  // Frame membership: set on an accepted start, held while bit 8 stays high,
  // cleared on truncation so the rest of that frame is ignored.
  always_comb begin
    in_frame_d = in_frame_q;
    if (!tx_i[8]) begin
      in_frame_d = 1'b0;
    end else if (accept_s) begin
      in_frame_d = 1'b1;
    end else if (trunc_s) begin
      in_frame_d = 1'b0;
    end else begin
      in_frame_d = in_frame_q;
    end
  end

  // Framer FSM: decides the byte that goes on the wire in the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    crc_d   = crc_q;
    bad_d   = bad_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    trunc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_PRE;
          cnt_d   = 8'd1;
          bcnt_d  = 11'd0;
          crc_d   = 32'hFFFF_FFFF;
          bad_d   = 1'b0;
          txen_d  = 1'b1;
          txd_d   = 8'h55;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        txen_d = 1'b1;
        if (cnt_q >= PRE_LAST) begin
          state_d = ST_SFD;
          txd_d   = 8'hD5;
        end else begin
          cnt_d = cnt_q + 8'd1;
          txd_d = 8'h55;
        end
      end
      ST_SFD, ST_DATA: begin
        txen_d = 1'b1;
        if (tail_vld_s) begin
          if (bcnt_q >= MAX_CNT) begin
            trunc_s = 1'b1;
            bad_d   = 1'b1;
            state_d = ST_FCS;
            cnt_d   = 8'd1;
            txd_d   = crc_q[7:0];
          end else begin
            state_d = ST_DATA;
            txd_d   = tail_data_s;
            crc_d   = crc32_byte(crc_q, tail_data_s);
            bcnt_d  = bcnt_q + 11'd1;
          end
        end else if (short_s) begin
          state_d = ST_PAD;
          txd_d   = 8'h00;
          crc_d   = crc32_byte(crc_q, 8'h00);
          bcnt_d  = (bcnt_q < MAX_CNT) ? bcnt_q + 11'd1 : bcnt_q;
        end else begin
          state_d = ST_FCS;
          cnt_d   = 8'd1;
          txd_d   = ~crc_q[7:0];
        end
      end
      ST_PAD: begin
        txen_d = 1'b1;
        if (bcnt_q < MIN_BODY) begin
          txd_d  = 8'h00;
          crc_d  = crc32_byte(crc_q, 8'h00);
          bcnt_d = (bcnt_q < MAX_CNT) ? bcnt_q + 11'd1 : bcnt_q;
        end else begin
          state_d = ST_FCS;
          cnt_d   = 8'd1;
          txd_d   = ~crc_q[7:0];
        end
      end
      ST_FCS: begin
        if (cnt_q < 8'd4) begin
          txen_d = 1'b1;
          txd_d  = fcs_s[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d  = cnt_q + 8'd1;
        end else begin
          state_d = ST_IFG;
          cnt_d   = 8'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q >= IFG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, CRC and registered outputs.
  always_ff @(posedge eth_rxck or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      bcnt_q     <= 11'd0;
      crc_q      <= 32'hFFFF_FFFF;
      bad_q      <= 1'b0;
      in_frame_q <= 1'b0;
      vld_prev_q <= 1'b0;
      txd_q      <= 8'h00;
      txen_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      crc_q      <= crc_d;
      bad_q      <= bad_d;
      in_frame_q <= in_frame_d;
      vld_prev_q <= tx_i[8];
      txd_q      <= txd_d;
      txen_q     <= txen_d;
      busy_q     <= (state_d != ST_IDLE);
      drop_q     <= drop_s;
      trunc_q    <= trunc_s;
    end
  end

  // Delay line; truncation flushes the valid bits so no stale body reaches the tail.
  always_ff @(posedge eth_rxck or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      for (int i = 0; i < DL_LEN; i++) begin
        dl_data_q[i] <= 8'h00;
      end
      dl_vld_q <= '0;
    end else begin
      dl_data_q[0] <= tx_i[7:0];
      for (int i = 1; i < DL_LEN; i++) begin
        dl_data_q[i] <= dl_data_q[i-1];
      end
      if (trunc_s) begin
        dl_vld_q <= '0;
      end else begin
        dl_vld_q <= {dl_vld_q[DL_LEN-2:0], in_vld_s};
      end
    end
  end

  assign gmii_txd  = txd_q;
  assign gmii_txen = txen_q;
  assign busy_o    = busy_q;
  assign drop_o    = drop_q;
  assign trunc_o   = trunc_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
`timescale 1ns/1ps
module tb_eth_tx_framer;
  localparam int PRE  = 7;
  localparam int IFG  = 12;
  localparam int MAXF = 64;

  logic       eth_rxck = 1'b0;
  logic       rst_rx_n;
  logic [8:0] tx_i;
  logic [7:0] gmii_txd;
  logic       gmii_txen;
  logic       busy_o;
  logic       drop_o;
  logic       trunc_o;

  always #4 eth_rxck = ~eth_rxck;

  eth_tx_framer #(
    .PREAMB_LEN(PRE),
    .IFG_LEN   (IFG),
    .MAX_FRAME (MAXF)
  ) dut (
    .eth_rxck (eth_rxck),
    .rst_rx_n (rst_rx_n),
    .tx_i     (tx_i),
    .gmii_txd (gmii_txd),
    .gmii_txen(gmii_txen),
    .busy_o   (busy_o),
    .drop_o   (drop_o),
    .trunc_o  (trunc_o)
  );

  typedef struct {
    int len;
    int seed;
    int exp_trunc;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] body [0:127];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         exp_cnt = 0;
  int         frm_idx = 0;
  int         txen_cycles = 0;
  int         drop_cnt = 0;
  int         trunc_cnt = 0;
  int         t_start = 0, t_first = -1, t_body = -1, t_last = -1, t_idle = -1;
  bit         txen_prev = 1'b0, busy_prev = 1'b0, fall_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) r = (r >> 1) ^ (32'hEDB88320 & {32{r[0]}});
    return r;
  endfunction

  // Scoreboard side: every byte on the wire is popped from exp_q and compared.
  task automatic monitor();
    if (!rst_rx_n) begin
      frm_idx   = 0;
      txen_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (gmii_txen) begin
        if (frm_idx == 0) t_first = cyc;
        if (frm_idx == PRE + 1) t_body = cyc;
        frm_idx++;
        txen_cycles++;
        t_last = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL txd_unexpected: actual byte %02h, required none (cycle %0d)", gmii_txd, cyc);
        end else begin
          chk("txd_byte", {24'd0, gmii_txd}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        chk("txd_idle_zero", {24'd0, gmii_txd}, 32'd0);
        if (txen_prev) fall_seen = 1'b1;
        frm_idx = 0;
      end
      if (busy_prev && !busy_o) t_idle = cyc;
      if (drop_o) drop_cnt++;
      if (trunc_o) trunc_cnt++;
      txen_prev = gmii_txen;
      busy_prev = busy_o;
    end
  endtask

  task automatic tick();
    @(negedge eth_rxck);
    cyc++;
    monitor();
  endtask

  // Reference framing of body[0..len-1] into the scoreboard queue.
  task automatic push_model(input int len);
    logic [31:0] crc;
    int          n;
    n   = (len > MAXF) ? MAXF : len;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(body[i]);
      crc = crc_upd(crc, body[i]);
    end
`ifdef TX_MIN_PAD_EN
    while (n < 60) begin
      exp_q.push_back(8'h00);
      crc = crc_upd(crc, 8'h00);
      n++;
    end
`endif
    if (len <= MAXF) crc = ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
    exp_cnt = PRE + 1 + n + 4;
  endtask

  // Known-answer frame for body "123456789".
  task automatic push_check_string();
    logic [7:0] fcs [4];
    fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[i]);
    exp_cnt = PRE + 1 + 9 + 4;
  endtask

  task automatic send_frame(input int len, input bit hard, input int rst_at);
    if (hard) push_check_string();
    else push_model(len);
    fall_seen = 1'b0;
    t_start = cyc;
    for (int i = 0; i < len; i++) begin
      tx_i = {1'b1, body[i]};
      tick();
      if (rst_at >= 0 && rst_rx_n && frm_idx == PRE + 2 + rst_at) begin
        chk("rst_pre_txen", {31'd0, gmii_txen}, 32'd1);
        #1 rst_rx_n = 1'b0;
        #1;
        chk("rst_async_txen", {31'd0, gmii_txen}, 32'd0);
        chk("rst_async_txd", {24'd0, gmii_txd}, 32'd0);
        chk("rst_async_busy", {31'd0, busy_o}, 32'd0);
        exp_q.delete();
      end
    end
    for (int i = 0; i < 4; i++) begin
      tx_i = {1'b0, 8'hA0 + 8'(i)};
      tick();
    end
    tx_i = 9'h000;
    if (!rst_rx_n) begin
      tick();
      rst_rx_n = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy_o || gmii_txen || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk("idle_reached", {31'd0, (!busy_o && !gmii_txen)}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic run_frame(input int len, input int exp_trunc, input bit hard);
    int d0, tr0, tx0;
    d0  = drop_cnt;
    tr0 = trunc_cnt;
    tx0 = txen_cycles;
    send_frame(len, hard, -1);
    wait_idle(400);
    chk("frame_txen_cycles", txen_cycles - tx0, exp_cnt);
    chk("frame_trunc_pulses", trunc_cnt - tr0, exp_trunc);
    chk("frame_drop_pulses", drop_cnt - d0, 32'd0);
    chk("frame_ifg", t_idle - t_last, IFG + 1);
    tick();
  endtask

  initial begin
    int k, d0, tx0;
    rst_rx_n = 1'b0;
    tx_i     = 9'h000;
    vecs[0] = '{len: 1,   seed: 3,  exp_trunc: 0};
    vecs[1] = '{len: 9,   seed: 5,  exp_trunc: 0};
    vecs[2] = '{len: 42,  seed: 7,  exp_trunc: 0};
    vecs[3] = '{len: 59,  seed: 11, exp_trunc: 0};
    vecs[4] = '{len: 60,  seed: 13, exp_trunc: 0};
    vecs[5] = '{len: 63,  seed: 29, exp_trunc: 0};
    vecs[6] = '{len: 64,  seed: 31, exp_trunc: 0};
    vecs[7] = '{len: 65,  seed: 37, exp_trunc: 1};
    vecs[8] = '{len: 100, seed: 41, exp_trunc: 1};

    repeat (3) tick();
    chk("reset_txen", {31'd0, gmii_txen}, 32'd0);
    chk("reset_txd", {24'd0, gmii_txd}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_drop", {31'd0, drop_o}, 32'd0);
    chk("reset_trunc", {31'd0, trunc_o}, 32'd0);
    rst_rx_n = 1'b1;
    repeat (2) tick();

    // Known-answer frame plus start-of-frame latencies.
    for (int i = 0; i < 9; i++) body[i] = 8'h31 + 8'(i);
`ifdef TX_MIN_PAD_EN
    run_frame(9, 0, 1'b0);
`else
    run_frame(9, 0, 1'b1);
`endif
    chk("lat_first_preamble", t_first - t_start, 32'd1);
    chk("lat_first_body", t_body - t_start, 32'd9);

    // Table-driven frames, including pad and truncation boundaries.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < vecs[v].len; i++) body[i] = 8'((i * vecs[v].seed + 17) % 256);
      run_frame(vecs[v].len, vecs[v].exp_trunc, 1'b0);
    end

    // Start during IFG cycle 5 is dropped; the following frame goes out.
    d0  = drop_cnt;
    tx0 = txen_cycles;
    for (int i = 0; i < 10; i++) body[i] = 8'h60 + 8'(i);
    send_frame(10, 1'b0, -1);
    k = 0;
    while (!(fall_seen && cyc == t_last + 5) && k < 200) begin
      tick();
      k++;
    end
    chk("drop_align", {31'd0, (fall_seen && cyc == t_last + 5)}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tx_i = {1'b1, 8'hE0 + 8'(i)};
      tick();
    end
    tx_i = 9'h000;
    wait_idle(400);
    chk("drop_pulses", drop_cnt - d0, 32'd1);
    chk("drop_txen_cycles", txen_cycles - tx0, exp_cnt);
    tick();
    for (int i = 0; i < 12; i++) body[i] = 8'h70 + 8'(i);
    run_frame(12, 0, 1'b0);

    // Reset during body byte 20, then a clean frame.
    for (int i = 0; i < 40; i++) body[i] = 8'h80 + 8'(i);
    send_frame(40, 1'b0, 20);
    wait_idle(400);
    repeat (2) tick();
    for (int i = 0; i < 20; i++) body[i] = 8'(i * 13 + 5);
    run_frame(20, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
